// File: rtl/distribution_hazard_scheduler_if.sv
// distribution_hazard_scheduler_if: ID/MEM request inputs and scheduler control outputs
interface distribution_hazard_scheduler_if;
   logic       ID_valid;
   logic [4:0] ID_srcAddr1;
   logic [4:0] ID_srcAddr2;
   logic       ID_issue;
   logic [4:0] ID_destAddr;
   logic [3:0] ID_opLatency;
   logic       MEM_DRegWrite;
   logic [4:0] MEM_destRegAddr;
   logic       stall;
   logic       DU_start;
   logic       WB_sel;
   logic [4:0] WB_destAddr;
   logic       MEM_hold;
   logic       busy;
   modport master (
      output ID_valid, ID_srcAddr1, ID_srcAddr2, ID_issue, ID_destAddr, ID_opLatency,
             MEM_DRegWrite, MEM_destRegAddr,
      input  stall, DU_start, WB_sel, WB_destAddr, MEM_hold, busy
   );
   modport slave (
      input  ID_valid, ID_srcAddr1, ID_srcAddr2, ID_issue, ID_destAddr, ID_opLatency,
             MEM_DRegWrite, MEM_destRegAddr,
      output stall, DU_start, WB_sel, WB_destAddr, MEM_hold, busy
   );
endinterface

// File: rtl/distribution_hazard_scheduler.sv
// distribution_hazard_scheduler: single-op DU scheduler with source, structural and write-port hazards.
// Define DIST_SCOREBOARD_BYPASS_EN to forward the DU result in WB instead of stalling dependents.
module distribution_hazard_scheduler (
   input logic                                  clk,
   input logic                                  rst,
   distribution_hazard_scheduler_if.slave       bus
);
   typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d, lat;
   logic       pend_valid_q, pend_valid_d;
   logic [4:0] pend_dest_q, pend_dest_d;
   logic       src_hit, src_haz, struct_haz, port_haz, accept, unused_mem;
   // MEM target address needs no decoding: any DU writeback takes the port
   assign unused_mem = ^bus.MEM_destRegAddr;
   assign lat = (bus.ID_opLatency == 4'd0) ? 4'd1 : bus.ID_opLatency;
   assign src_hit = bus.ID_valid & pend_valid_q &
                    (((bus.ID_srcAddr1 == pend_dest_q) & (bus.ID_srcAddr1 != 5'd0)) |
                     ((bus.ID_srcAddr2 == pend_dest_q) & (bus.ID_srcAddr2 != 5'd0)));
`ifdef DIST_SCOREBOARD_BYPASS_EN
   assign src_haz = src_hit & (state_q != WB);
`else
   assign src_haz = src_hit;
`endif
   assign struct_haz = bus.ID_issue & (state_q != IDLE);
   assign port_haz = (state_q == WB) & bus.MEM_DRegWrite;
   assign bus.stall = src_haz | struct_haz | port_haz;
   assign accept = (state_q == IDLE) & bus.ID_issue & ~bus.stall & ~rst;
   assign bus.DU_start = accept;
   assign bus.WB_sel = (state_q == WB);
   assign bus.WB_destAddr = (state_q == WB) ? pend_dest_q : 5'd0;
   assign bus.MEM_hold = port_haz;
   assign bus.busy = (state_q != IDLE);
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      pend_valid_d = pend_valid_q;
      pend_dest_d = pend_dest_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = (lat == 4'd1) ? WB : RUN;
            cnt_d = lat - 4'd1;
            pend_dest_d = bus.ID_destAddr;
            pend_valid_d = |bus.ID_destAddr;
         end
         RUN: begin
            state_d = (cnt_q <= 4'd1) ? WB : RUN;
            cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
         end
         WB: begin
            state_d = IDLE;
            pend_valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= 4'd0;
         pend_valid_q <= 1'b0;
         pend_dest_q <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_dest_q <= pend_dest_d;
      end
   end
endmodule

// File: tb/tb_distribution_hazard_scheduler.sv
// tb_distribution_hazard_scheduler: randomized + directed scoreboard bench against a cycle-number model.
module tb_distribution_hazard_scheduler;
   typedef struct packed {
      logic       stall;
      logic       start;
      logic       wb_sel;
      logic [4:0] wb_dest;
      logic       hold;
      logic       busy;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   distribution_hazard_scheduler_if bus();
   distribution_hazard_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
   exp_t       expq[$];
   int         wb_cyc_q[$];
   logic [4:0] wb_dest_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   bit         have_op = 1'b0;
   int         wb_cyc = 0;
   logic [4:0] op_dest = 5'd0;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask
   // The model tracks the in-flight op as "writes back on cycle wb_cyc"
   task automatic step(input logic r, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic iss, input logic [4:0] d, input logic [3:0] l, input logic mw);
      bit   inflight, in_wb, hit, st, start;
      exp_t e;
      @(negedge clk);
      cyc++;
      rst = r;
      bus.ID_valid = v;
      bus.ID_srcAddr1 = s1;
      bus.ID_srcAddr2 = s2;
      bus.ID_issue = iss;
      bus.ID_destAddr = d;
      bus.ID_opLatency = l;
      bus.MEM_DRegWrite = mw;
      bus.MEM_destRegAddr = 5'($urandom_range(31));
      e = '0;
      if (r) begin
         have_op = 1'b0;
         wb_cyc_q.delete();
         wb_dest_q.delete();
      end else begin
         inflight = have_op && cyc <= wb_cyc;
         in_wb = have_op && cyc == wb_cyc;
         hit = v && inflight && op_dest != 5'd0 &&
               ((s1 == op_dest && s1 != 5'd0) || (s2 == op_dest && s2 != 5'd0));
`ifdef DIST_SCOREBOARD_BYPASS_EN
         if (in_wb) hit = 1'b0;
`endif
         st = hit || (iss && inflight) || (in_wb && mw);
         start = iss && !inflight && !st;
         e.stall = st;
         e.start = start;
         e.wb_sel = in_wb;
         e.wb_dest = in_wb ? op_dest : 5'd0;
         e.hold = in_wb && mw;
         e.busy = inflight;
         if (start) begin
            have_op = 1'b1;
            op_dest = d;
            wb_cyc = cyc + ((l == 4'd0) ? 1 : int'(l));
            wb_cyc_q.push_back(wb_cyc);
            wb_dest_q.push_back(d);
         end
      end
      expq.push_back(e);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("stall", int'(bus.stall), int'(e.stall));
            chk("DU_start", int'(bus.DU_start), int'(e.start));
            chk("WB_sel", int'(bus.WB_sel), int'(e.wb_sel));
            chk("WB_destAddr", int'(bus.WB_destAddr), int'(e.wb_dest));
            chk("MEM_hold", int'(bus.MEM_hold), int'(e.hold));
            chk("busy", int'(bus.busy), int'(e.busy));
         end
         if (bus.WB_sel) begin
            if (wb_cyc_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_spurious cycle %0d: got WB_sel=1 dest %0d expected no writeback", cyc, bus.WB_destAddr);
            end else begin
               chk("wb_cycle", cyc, wb_cyc_q.pop_front());
               chk("wb_event_dest", int'(bus.WB_destAddr), int'(wb_dest_q.pop_front()));
            end
         end
      end
   end
   initial begin : stimulus
      bus.ID_valid = 1'b0;
      bus.ID_srcAddr1 = 5'd0;
      bus.ID_srcAddr2 = 5'd0;
      bus.ID_issue = 1'b0;
      bus.ID_destAddr = 5'd0;
      bus.ID_opLatency = 4'd0;
      bus.MEM_DRegWrite = 1'b0;
      bus.MEM_destRegAddr = 5'd0;
      step(1, 1, 3, 3, 1, 3, 2, 1);
      step(1, 0, 0, 0, 1, 5, 1, 1);
      step(0, 0, 0, 0, 1, 2, 2, 0);
      idle(3);
      step(0, 0, 0, 0, 1, 5, 3, 0);
      idle(4);
      step(0, 0, 0, 0, 1, 7, 4, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 7, 1, 0, 0, 0, 0);
      idle(2);
      step(0, 0, 0, 0, 1, 3, 2, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 9, 1, 0);
      idle(3);
      step(0, 0, 0, 0, 1, 4, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 6, 6, 0);
      step(0, 1, 6, 0, 0, 0, 0, 0);
      step(1, 1, 6, 0, 1, 2, 1, 1);
      idle(10);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 1);
      idle(2);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(99) == 0, $urandom_range(1) == 1,
              5'($urandom_range(7)), 5'($urandom_range(7)),
              $urandom_range(2) == 0, 5'($urandom_range(7)),
              4'($urandom_range(15)), $urandom_range(9) < 3);
      idle(20);
      for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("queue_drained", expq.size(), 0);
      chk("wb_outstanding", wb_cyc_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/distribution_hazard_scheduler.md
DISTRIBUTION_HAZARD_SCHEDULER -- requirements
Module: distribution_hazard_scheduler

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port ID_valid  input  1  ID-stage instruction reads distribution sources.
REQ-004 SHALL have ports ID_srcAddr1, ID_srcAddr2  input  5 each  distribution source register addresses.
REQ-005 SHALL have port ID_issue  input  1  ID-stage instruction requests the multi-cycle distribution unit (DU).
REQ-006 SHALL have port ID_destAddr  input  5  DU destination register.
REQ-007 SHALL have port ID_opLatency  input  4  DU latency in cycles; value 0 treated as 1.
REQ-008 SHALL have ports MEM_DRegWrite  input  1 and MEM_destRegAddr  input  5  single-cycle distribution writeback request.
REQ-009 SHALL have port stall  output  1  freeze IF/ID.
REQ-010 SHALL have port DU_start  output  1  one-cycle DU launch pulse.
REQ-011 SHALL have ports WB_sel  output  1 and WB_destAddr  output  5  DU owns distribution write port this cycle; target register.
REQ-012 SHALL have port MEM_hold  output  1  MEM writeback deferred one cycle.
REQ-013 SHALL have port busy  output  1  DU operation in flight (state != IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, WB; one DU operation in flight maximum.
REQ-015 IDLE: ID_issue=1 and stall=0 SHALL assert DU_start that cycle, latch ID_destAddr into pendDest, load counter=max(ID_opLatency,1)-1, go to WB if counter=0, else RUN.
REQ-016 RUN: counter SHALL decrement by 1 per cycle; at counter=1 next state SHALL be WB; counter SHALL never wrap below 0.
REQ-017 WB: WB_sel=1, WB_destAddr=pendDest for exactly one cycle; next state IDLE.
REQ-018 Issue latency: DU_start at cycle T with latency L SHALL give WB_sel at cycle T+L.
REQ-019 pendValid SHALL set on accepted issue and clear on the WB-to-IDLE transition; pendDest=0 SHALL never set pendValid.
REQ-020 Source hazard: ID_valid=1 and pendValid=1 and (ID_srcAddr1 or ID_srcAddr2 == pendDest, address nonzero) SHALL assert stall.
REQ-021 Structural hazard: ID_issue=1 while state != IDLE SHALL assert stall; no DU_start.
REQ-022 Write-port conflict: WB_sel=1 and MEM_DRegWrite=1 same cycle SHALL assert MEM_hold=1 and stall=1 that cycle; DU wins the port.
REQ-023 stall SHALL be the OR of REQ-020/021/022 conditions; purely combinational from state and inputs.
REQ-024 DU_start SHALL never assert in the same cycle as stall.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, counter=0, pendValid=0, pendDest=0.
REQ-026 Under reset, stall, DU_start, WB_sel, MEM_hold, busy SHALL be 0 and WB_destAddr SHALL be 0.
REQ-027 Reset mid-RUN or mid-WB SHALL abandon the operation with no WB_sel pulse after release.
REQ-028 First issue SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro DIST_SCOREBOARD_BYPASS_EN defined: in WB, a source match on pendDest SHALL NOT stall (result forwarded from DU output).
REQ-030 Macro undefined: source match SHALL stall through WB inclusive; dependent instruction proceeds the cycle after WB.

Verification
REQ-031 Issue dest=5, latency=3 at T -> DU_start at T, busy T+1..T+3, WB_sel=1 with WB_destAddr=5 at T+3 only.
REQ-032 Issue dest=7, latency=4; ID_valid with src1=7 from T+1 -> stall=1 through T+3 (bypass) or T+4 (no bypass), 0 after.
REQ-033 Second ID_issue at T+1 during latency=2 op -> stall=1, no DU_start until IDLE; accepted at T+3.
REQ-034 latency=1, MEM_DRegWrite=1 at T+1 -> WB_sel=1, MEM_hold=1, stall=1 at T+1; MEM_hold=0 at T+2.
REQ-035 rst pulse at T+2 of latency=6 op -> all outputs 0 immediately, no WB_sel in following 10 cycles.
REQ-036 Issue dest=0, latency=0 -> treated as latency 1; src=0 reads never stall.
